spi_slave_regfile: RTL



---
 rtl/spi_slave_pkg.sv | 13 +
 rtl/spi_slave_regfile_edge_sync.sv | 55 +++++
 rtl/spi_slave_regfile.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave register file.
package spi_slave_pkg;

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_e;

    localparam int CMD_W       = 8;
    localparam int ADDR_STREAM = 0;
    localparam int ADDR_CONFIG = 1;
    localparam int ADDR_IRQ    = 2;
    localparam int IRQ_EN_BIT  = 0;
    localparam int IRQ_CLR_BIT = 1;

endpackage

// File: rtl/spi_slave_regfile_edge_sync.sv
// Synchronises the SPI pins into clk_i and turns SCK/CS transitions into
// single-cycle sample/shift and CS fall/rise pulses for the selected SPI mode.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic spi_clk_i,
    input  logic spi_cs_n_i,
    input  logic spi_sdi_i,
    output logic sdi_o,
    output logic sample_pulse_o,
    output logic shift_pulse_o,
    output logic cs_fall_o,
    output logic cs_rise_o
);

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, sdi_sync_q;
    logic                   sck_prev_q, cs_prev_q;
    logic                   sck_now, cs_now, sck_rise, sck_fall, leading, trailing;

    // CS chain resets to "selected": a frame still in progress when reset is
    // released must not look like a fresh CS fall, only a real rise-then-fall.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sck_sync_q <= {SYNC_STAGES{CPOL}};
            cs_sync_q  <= '0;
            sdi_sync_q <= '0;
            sck_prev_q <= CPOL;
            cs_prev_q  <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk_i};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi_i};
            sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
            cs_prev_q  <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_now  = sck_sync_q[SYNC_STAGES-1];
    assign cs_now   = cs_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_now & ~sck_prev_q;
    assign sck_fall = ~sck_now & sck_prev_q;
    assign leading  = CPOL ? sck_fall : sck_rise;
    assign trailing = CPOL ? sck_rise : sck_fall;

    assign sdi_o          = sdi_sync_q[SYNC_STAGES-1];
    assign sample_pulse_o = CPHA ? trailing : leading;
    assign shift_pulse_o  = CPHA ? leading : trailing;
    assign cs_fall_o      = ~cs_now & cs_prev_q;
    assign cs_rise_o      = cs_now & ~cs_prev_q;

endmodule

// File: rtl/spi_slave_regfile.sv
// Oversampling SPI slave with command/address framing, burst auto-increment,
// a small register file (stream, config, IRQ control, scratch) and an IRQ line.
//
//   state | meaning
//   IDLE  | not selected, waiting for CS fall
//   CMD   | shifting in the 8-bit command
//   WDATA | receiving write words, commit each to addr, addr++
//   RDATA | shifting out read words, reload from addr+1 after each
module spi_slave_regfile import spi_slave_pkg::*; #(
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              spi_clk_i,
    input  logic              spi_cs_n_i,
    input  logic              spi_sdi_i,
    output logic              spi_sdo_o,
    output logic              spi_sdo_oe_o,
    output logic [DATA_W-1:0] data_out_o,
    output logic              data_out_enable_o,
    output logic [DATA_W-1:0] config_o,
    input  logic              irq_req_i,
    output logic              spi_irq_o,
    output logic              frame_active_o
);

    localparam int AW    = $clog2(NUM_REGS);
    localparam int CNT_W = $clog2(DATA_W);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [DATA_W-1:0]   shift_in_q, shift_out_q, data_out_q, rd_data;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [AW-1:0]       addr_q, cmd_addr, rd_addr;
    logic                cmd_done_q, word_done_q, data_out_en_q;
    logic                irq_en_q, irq_pend_q, irq_pend_d, irq_req_q, spi_irq_q, irq_clr;
    logic                sdi, sample_pulse, shift_pulse, cs_fall, cs_rise;

    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .CPOL        (CPOL),
        .CPHA        (CPHA)
    ) u_sync (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .spi_clk_i      (spi_clk_i),
        .spi_cs_n_i     (spi_cs_n_i),
        .spi_sdi_i      (spi_sdi_i),
        .sdi_o          (sdi),
        .sample_pulse_o (sample_pulse),
        .shift_pulse_o  (shift_pulse),
        .cs_fall_o      (cs_fall),
        .cs_rise_o      (cs_rise)
    );

    assign cmd_addr = shift_in_q[AW-1:0];

    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (cs_fall) state_d = CMD;
                CMD:     if (cmd_done_q) state_d = shift_in_q[CMD_W-1] ? WDATA : RDATA;
                default: ;
            endcase
        end
    end

    // Stream and IRQ addresses read back the IRQ status, not stored data.
    always_comb begin
        rd_addr = (state_q == CMD) ? cmd_addr : addr_q + AW'(1);
        rd_data = regs_q[rd_addr];
        if (rd_addr == AW'(ADDR_STREAM) || rd_addr == AW'(ADDR_IRQ)) begin
            rd_data              = '0;
            rd_data[IRQ_EN_BIT]  = irq_en_q;
            rd_data[IRQ_CLR_BIT] = irq_pend_q;
        end
    end

    // A new request edge in the same cycle as a clear keeps the IRQ pending.
    always_comb begin
        irq_clr    = (state_q == WDATA) && word_done_q && (addr_q == AW'(ADDR_IRQ))
                     && shift_in_q[IRQ_CLR_BIT];
        irq_pend_d = irq_pend_q;
        if (irq_clr) irq_pend_d = 1'b0;
        if (irq_req_i && !irq_req_q) irq_pend_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_in_q    <= '0;
            shift_out_q   <= '0;
            data_out_q    <= '0;
            data_out_en_q <= 1'b0;
            addr_q        <= '0;
            cmd_done_q    <= 1'b0;
            word_done_q   <= 1'b0;
            irq_en_q      <= 1'b0;
            irq_pend_q    <= 1'b0;
            irq_req_q     <= 1'b0;
            spi_irq_q     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            cmd_done_q    <= 1'b0;
            word_done_q   <= 1'b0;
            data_out_en_q <= 1'b0;
            irq_req_q     <= irq_req_i;
            irq_pend_q    <= irq_pend_d;
            spi_irq_q     <= irq_pend_q & irq_en_q;

            if (state_d != state_q) begin
                bit_cnt_q <= '0;
            end else if (sample_pulse && state_q != IDLE) begin
                shift_in_q <= {shift_in_q[DATA_W-2:0], sdi};
                if ((state_q == CMD && bit_cnt_q == CNT_W'(CMD_W-1)) ||
                    (state_q != CMD && bit_cnt_q == CNT_W'(DATA_W-1))) begin
                    bit_cnt_q <= '0;
                    if (state_q == CMD) cmd_done_q  <= 1'b1;
                    else                word_done_q <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                end
            end

            // Shifting waits for the first sample of a word so the freshly
            // loaded MSB survives the shift edge that precedes it.
            if (state_q == CMD && cmd_done_q) begin
                addr_q      <= cmd_addr;
                shift_out_q <= rd_data;
            end else if (state_q == RDATA && word_done_q) begin
                addr_q      <= addr_q + AW'(1);
                shift_out_q <= rd_data;
            end else if (state_q == RDATA && shift_pulse && bit_cnt_q != '0) begin
                shift_out_q <= {shift_out_q[DATA_W-2:0], 1'b0};
            end

            if (state_q == WDATA && word_done_q) begin
                addr_q <= addr_q + AW'(1);
                if (addr_q == AW'(ADDR_STREAM)) begin
                    data_out_q    <= shift_in_q;
                    data_out_en_q <= 1'b1;
                end else if (addr_q == AW'(ADDR_IRQ)) begin
                    irq_en_q <= shift_in_q[IRQ_EN_BIT];
                end else begin
                    regs_q[addr_q] <= shift_in_q;
                end
            end
        end
    end

    assign spi_sdo_o         = (state_q == RDATA) ? shift_out_q[DATA_W-1] : 1'b0;
    assign spi_sdo_oe_o      = (state_q != IDLE);
    assign frame_active_o    = (state_q != IDLE);
    assign data_out_o        = data_out_q;
    assign data_out_enable_o = data_out_en_q;
    assign config_o          = regs_q[ADDR_CONFIG];
    assign spi_irq_o         = spi_irq_q;

endmodule
